bmux_pipe: RTL and testbench

- Parametrised, registered successor to the B-bus misc-value generator in the datapath.
- Latches the instruction word and produces constants (0, +2, -4) and sign-extended branch or load/store offsets on BBUS.
- Adds three things:
  - a valid/ready output stage;
  - an immediate-prefix register that widens the next offset;
  - a sticky error flag for illegal selects.
- Sits between the IR/decode logic and the ALU B-operand port.

---
 rtl/bmux_pkg.sv | 33 +++
 rtl/bmux_pipe_if.sv | 31 +++
 rtl/bmux_imm.sv | 57 +++++
 rtl/bmux_pipe.sv | 96 +++++++++
 tb/tb_bmux_pipe.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/bmux_pkg.sv
// rtl/bmux_pkg.sv - shared select codes and constant helpers for the B-bus value pipe
package bmux_pkg;

  localparam logic [2:0] SEL_ZERO   = 3'd0;
  localparam logic [2:0] SEL_CON_2  = 3'd1;
  localparam logic [2:0] SEL_CON_N4 = 3'd2;
  localparam logic [2:0] SEL_IRBROF = 3'd3;
  localparam logic [2:0] SEL_IRLSOF = 3'd4;
  localparam logic [2:0] SEL_PFX    = 3'd5;

  localparam int CONST_MAX_W = 64;

  function automatic logic [CONST_MAX_W-1:0] width_mask(input int w);
    logic [CONST_MAX_W-1:0] m;
    if (w >= CONST_MAX_W) m = '1;
    else m = (64'd1 << w) - 64'd1;
    return m;
  endfunction

  function automatic logic [CONST_MAX_W-1:0] con_2(input int w);
    return 64'd2 & width_mask(w);
  endfunction

  // -4 in two's complement: every bit set except the two LSBs
  function automatic logic [CONST_MAX_W-1:0] con_n4(input int w);
    return ~64'd3 & width_mask(w);
  endfunction

  function automatic logic is_offset(input logic [2:0] sel);
    return (sel == SEL_IRBROF) || (sel == SEL_IRLSOF);
  endfunction

endpackage

// File: rtl/bmux_pipe_if.sv
// rtl/bmux_pipe_if.sv - request and result handshake bundle for bmux_pipe
interface bmux_pipe_if #(
  parameter int W = 16
);

  logic [2:0]   sel;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] q;
  logic         q_valid;
  logic         q_ready;

  modport master (
    output sel,
    output in_valid,
    output q_ready,
    input  in_ready,
    input  q,
    input  q_valid
  );

  modport slave (
    input  sel,
    input  in_valid,
    input  q_ready,
    output in_ready,
    output q,
    output q_valid
  );

endinterface

// File: rtl/bmux_imm.sv
// rtl/bmux_imm.sv - combinational B-bus value generator (constants and sign-extended offsets)
module bmux_imm
  import bmux_pkg::*;
#(
  parameter int W        = 16,
  parameter int BROF_MSB = 9,
  parameter int LSOF_MSB = 6,
  parameter int PFX_W    = 8
) (
  input  logic [W-1:0]     irreg,
  input  logic [2:0]       sel,
  input  logic [PFX_W-1:0] ext,
  input  logic             ext_vld,
  output logic [W-1:0]     value,
  output logic             illegal
);

  localparam int BR_W = BROF_MSB + 1;
  localparam int LS_W = LSOF_MSB + 1;
  localparam int HI_MSB = (BROF_MSB > LSOF_MSB) ? BROF_MSB : LSOF_MSB;

  logic [BR_W-1:0] br_raw;
  logic [LS_W-1:0] ls_raw;

  // Branch offsets are halfword-scaled, so bit 0 of the field is forced to zero
  assign br_raw = {irreg[BROF_MSB:1], 1'b0};
  assign ls_raw = irreg[LSOF_MSB:0];

  generate
    if (HI_MSB < W - 1) begin : g_hi_sink
      logic unused_irreg_hi;
      assign unused_irreg_hi = ^irreg[W-1:HI_MSB+1];
    end
  endgenerate

  // Replicating the sign bit W times then casting to W both extends and drops excess bits
  always_comb begin
    value   = '0;
    illegal = 1'b0;
    case (sel)
      SEL_ZERO:   value = '0;
      SEL_CON_2:  value = W'(con_2(W));
      SEL_CON_N4: value = W'(con_n4(W));
      SEL_IRBROF: begin
        if (ext_vld) value = W'({{W{ext[PFX_W-1]}}, ext, br_raw});
        else         value = W'({{W{br_raw[BR_W-1]}}, br_raw});
      end
      SEL_IRLSOF: begin
        if (ext_vld) value = W'({{W{ext[PFX_W-1]}}, ext, ls_raw});
        else         value = W'({{W{ls_raw[LS_W-1]}}, ls_raw});
      end
      SEL_PFX:    value = '0;
      default:    illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/bmux_pipe.sv
// rtl/bmux_pipe.sv - registered B-bus value generator with prefix, handshake and error flag
module bmux_pipe
  import bmux_pkg::*;
#(
  parameter int W        = 16,
  parameter int BROF_MSB = 9,
  parameter int LSOF_MSB = 6,
  parameter int PFX_W    = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ir_ld,
  input  logic [W-1:0] ir,
  input  logic         err_clr,
  output logic         err,
  bmux_pipe_if.slave   bus
);

  logic [W-1:0]     irreg;
  logic [PFX_W-1:0] ext;
  logic             ext_vld;
  logic [W-1:0]     q_reg;
  logic             q_valid_reg;
  logic [W-1:0]     imm_value;
  logic             imm_illegal;
  logic             accept;
  logic             accept_pfx;
  logic             accept_out;

  // Single output register without skid: a new request fits only if Q is empty or leaving now
  assign bus.in_ready = !q_valid_reg || bus.q_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign accept_pfx   = accept && (bus.sel == SEL_PFX);
  assign accept_out   = accept && (bus.sel != SEL_PFX);

  assign bus.q       = q_reg;
  assign bus.q_valid = q_valid_reg;

  bmux_imm #(
    .W       (W),
    .BROF_MSB(BROF_MSB),
    .LSOF_MSB(LSOF_MSB),
    .PFX_W   (PFX_W)
  ) u_imm (
    .irreg  (irreg),
    .sel    (bus.sel),
    .ext    (ext),
    .ext_vld(ext_vld),
    .value  (imm_value),
    .illegal(imm_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irreg <= '0;
    end else if (ir_ld) begin
      irreg <= ir;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext     <= '0;
      ext_vld <= 1'b0;
    end else if (accept_pfx) begin
      ext     <= irreg[PFX_W-1:0];
      ext_vld <= 1'b1;
    end else if (accept_out && is_offset(bus.sel)) begin
      ext_vld <= 1'b0;
    end
  end

  // A prefix accept is not an output load, so a concurrent consume still empties Q
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg       <= '0;
      q_valid_reg <= 1'b0;
    end else if (accept_out) begin
      q_reg       <= imm_value;
      q_valid_reg <= 1'b1;
    end else if (bus.q_ready) begin
      q_valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (accept_out && imm_illegal) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bmux_pipe.sv
// tb/tb_bmux_pipe.sv - self-checking bench for bmux_pipe against an arithmetic reference model
module tb_bmux_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ir_ld = 1'b0;
  logic [15:0] ir = '0;
  logic        err_clr = 1'b0;
  logic        err;

  bmux_pipe_if #(.W(16)) bus ();

  bmux_pipe #(
    .W       (16),
    .BROF_MSB(9),
    .LSOF_MSB(6),
    .PFX_W   (8)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ir_ld  (ir_ld),
    .ir     (ir),
    .err_clr(err_clr),
    .err    (err),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] m_irreg;
  logic [7:0]  m_ext;
  bit          m_ev;
  logic [15:0] m_q;
  bit          m_qv;
  bit          m_err;

  // Offsets from plain integer arithmetic: field value, then signed range fold
  function automatic logic [15:0] ref_value(input int s, input logic [15:0] r,
                                            input logic [7:0] e, input bit ev);
    longint v;
    longint se;
    se = (e >= 128) ? longint'(e) - 256 : longint'(e);
    case (s)
      0: v = 0;
      1: v = 2;
      2: v = -4;
      3: begin
        v = (longint'(r) % 1024) - (longint'(r) % 2);
        if (ev) v = se * 1024 + v;
        else if (v >= 512) v = v - 1024;
      end
      4: begin
        v = longint'(r) % 128;
        if (ev) v = se * 128 + v;
        else if (v >= 64) v = v - 128;
      end
      default: v = 0;
    endcase
    return 16'(v);
  endfunction

  task automatic model_reset();
    m_irreg = '0; m_ext = '0; m_ev = 0; m_q = '0; m_qv = 0; m_err = 0;
  endtask

  task automatic drive(input bit ld, input logic [15:0] irv, input bit vld,
                       input logic [2:0] s, input bit rdy, input bit clr);
    ir_ld = ld; ir = irv; bus.in_valid = vld; bus.sel = s; bus.q_ready = rdy; err_clr = clr;
    #1;
  endtask

  task automatic tick();
    bit acc;
    int s;
    s = int'(bus.sel);
    acc = bus.in_valid && (!m_qv || bus.q_ready);
    if (acc && s == 5) begin
      m_ext = m_irreg[7:0];
      m_ev  = 1;
    end
    if (acc && s != 5) begin
      m_q  = ref_value(s, m_irreg, m_ext, m_ev);
      m_qv = 1;
      if (s == 3 || s == 4) m_ev = 0;
    end else if (bus.q_ready) begin
      m_qv = 0;
    end
    if (acc && s > 5) m_err = 1;
    else if (err_clr) m_err = 0;
    if (ir_ld) m_irreg = ir;
    @(posedge clk);
    #1;
  endtask

  task automatic load_ir(input logic [15:0] v);
    drive(1, v, 0, 3'd0, 1, 0);
    tick();
  endtask

  task automatic req(input logic [2:0] s);
    drive(0, ir, 1, s, 1, 0);
    tick();
  endtask

  task automatic test_reset();
    n_tests++; if (bus.q !== 16'h0000) begin n_fail++; $display("FAIL reset_q got=%h exp=0000", bus.q); end
    n_tests++; if (bus.q_valid !== 1'b0) begin n_fail++; $display("FAIL reset_q_valid got=%b exp=0", bus.q_valid); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err); end
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_offsets();
    load_ir(16'h0201);
    req(3'd3);
    n_tests++; if (bus.q !== 16'hFE00 || bus.q_valid !== 1'b1) begin n_fail++; $display("FAIL brof_neg got=%h/%b exp=fe00/1", bus.q, bus.q_valid); end
    load_ir(16'h0045);
    req(3'd4);
    n_tests++; if (bus.q !== 16'hFFC5) begin n_fail++; $display("FAIL lsof_neg got=%h exp=ffc5", bus.q); end
  endtask

  task automatic test_prefix();
    logic [15:0] q_before;
    logic        v_before;
    load_ir(16'h0003);
    q_before = bus.q; v_before = bus.q_valid;
    drive(0, ir, 1, 3'd5, 0, 0);
    tick();
    n_tests++; if (bus.q !== q_before || bus.q_valid !== v_before) begin n_fail++; $display("FAIL pfx_no_output got=%h/%b exp=%h/%b", bus.q, bus.q_valid, q_before, v_before); end
    load_ir(16'h0005);
    req(3'd4);
    n_tests++; if (bus.q !== 16'h0185) begin n_fail++; $display("FAIL lsof_prefixed got=%h exp=0185", bus.q); end
    req(3'd4);
    n_tests++; if (bus.q !== 16'h0005) begin n_fail++; $display("FAIL prefix_consumed got=%h exp=0005", bus.q); end
  endtask

  task automatic test_prefix_const();
    load_ir(16'h00FF);
    req(3'd5);
    req(3'd1);
    n_tests++; if (bus.q !== 16'h0002) begin n_fail++; $display("FAIL con2_keeps_pfx got=%h exp=0002", bus.q); end
    load_ir(16'h0000);
    req(3'd3);
    n_tests++; if (bus.q !== 16'hFC00 || bus.q !== m_q) begin n_fail++; $display("FAIL brof_prefixed got=%h exp=fc00 model=%h", bus.q, m_q); end
  endtask

  task automatic test_back_to_back();
    req(3'd2);
    n_tests++; if (bus.q !== 16'hFFFC) begin n_fail++; $display("FAIL con_n4 got=%h exp=fffc", bus.q); end
    drive(0, ir, 1, 3'd1, 0, 0);
    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready got=%b exp=0", bus.in_ready); end
    tick();
    n_tests++; if (bus.q !== 16'hFFFC || bus.q_valid !== 1'b1) begin n_fail++; $display("FAIL stall_hold got=%h/%b exp=fffc/1", bus.q, bus.q_valid); end
    drive(0, ir, 1, 3'd1, 1, 0);
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL replace_in_ready got=%b exp=1", bus.in_ready); end
    tick();
    n_tests++; if (bus.q !== 16'h0002 || bus.q_valid !== 1'b1) begin n_fail++; $display("FAIL replace got=%h/%b exp=0002/1", bus.q, bus.q_valid); end
    drive(0, ir, 0, 3'd0, 1, 0);
    tick();
    n_tests++; if (bus.q_valid !== 1'b0) begin n_fail++; $display("FAIL drain got=%b exp=0", bus.q_valid); end
  endtask

  task automatic test_error();
    req(3'd6);
    n_tests++; if (bus.q !== 16'h0000 || err !== 1'b1) begin n_fail++; $display("FAIL reserved got=%h/%b exp=0000/1", bus.q, err); end
    req(3'd0);
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky got=%b exp=1", err); end
    drive(0, ir, 0, 3'd0, 1, 1);
    tick();
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_clr got=%b exp=0", err); end
    drive(0, ir, 1, 3'd7, 1, 1);
    tick();
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_set_wins got=%b exp=1", err); end
  endtask

  task automatic test_ir_same_cycle();
    load_ir(16'h0011);
    drive(1, 16'h0070, 1, 3'd4, 1, 0);
    tick();
    n_tests++; if (bus.q !== 16'h0011) begin n_fail++; $display("FAIL old_irreg got=%h exp=0011", bus.q); end
    req(3'd4);
    n_tests++; if (bus.q !== 16'hFFF0) begin n_fail++; $display("FAIL new_irreg got=%h exp=fff0", bus.q); end
  endtask

  task automatic test_reset_mid();
    load_ir(16'h0003);
    req(3'd5);
    drive(0, ir, 1, 3'd6, 0, 0);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_tests++; if (bus.q !== 16'h0000 || bus.q_valid !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL async_reset got=%h/%b/%b exp=0000/0/0", bus.q, bus.q_valid, err); end
    #3;
    rst_n = 1'b1;
    load_ir(16'h0005);
    req(3'd4);
    n_tests++; if (bus.q !== 16'h0005) begin n_fail++; $display("FAIL pfx_discarded got=%h exp=0005", bus.q); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 3, 16'($urandom), $urandom_range(0, 9) < 7,
            3'($urandom_range(0, 7)), $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
      n_tests++; if (bus.in_ready !== (!m_qv || bus.q_ready)) begin n_fail++; $display("FAIL rnd_in_ready[%0d] got=%b exp=%b", i, bus.in_ready, (!m_qv || bus.q_ready)); end
      tick();
      n_tests++; if (bus.q !== m_q || bus.q_valid !== m_qv || err !== m_err) begin
        n_fail++; $display("FAIL rnd_out[%0d] got=%h/%b/%b exp=%h/%b/%b", i, bus.q, bus.q_valid, err, m_q, m_qv, m_err);
      end
    end
  endtask

  initial begin
    bus.sel = '0; bus.in_valid = 1'b0; bus.q_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    test_reset();
    test_offsets();
    test_prefix();
    test_prefix_const();
    test_back_to_back();
    test_error();
    test_ir_same_cycle();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
